// File: rtl/vdp_sprite_hit_scan_pkg.sv
// Shared sprite hit-list definitions: entry layout, terminator, sprite heights
// and the scanner FSM encoding.
package vdp_sprite_hit_scan_pkg;

  localparam int HL_ENTRY_W   = 14;
  localparam int HL_ID_LSB    = 6;
  localparam int HL_ID_W      = 8;
  localparam int HL_OFS_LSB   = 2;
  localparam int HL_OFS_W     = 4;
  localparam int HL_WIDTH_BIT = 1;
  localparam int HL_END_BIT   = 0;

  localparam logic [HL_ENTRY_W-1:0] HL_TERMINATOR = 14'h0001;

  localparam logic [4:0] HEIGHT_8  = 5'd8;
  localparam logic [4:0] HEIGHT_16 = 5'd16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_TERM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic [HL_ENTRY_W-1:0] hl_entry(
    input logic [HL_ID_W-1:0]  id,
    input logic [HL_OFS_W-1:0] ofs,
    input logic                wsel
  );
    return {id, ofs, wsel, 1'b0};
  endfunction

endpackage

// File: rtl/vdp_sprite_hit_scan_y_test.sv
// Combinational vertical hit test for one sprite against one raster line,
// with wrap-around at line 512 and optional vertical flip.
module vdp_sprite_y_test
  import vdp_sprite_hit_scan_pkg::*;
(
  input  logic [8:0] render_y_i,
  input  logic [8:0] sprite_y_i,
  input  logic       height_select_i,
  input  logic       flip_y_i,
  output logic       hit_o,
  output logic [3:0] line_offset_o
);

  logic [8:0] delta;
  logic [4:0] height;
  logic [3:0] flip_mask;

  always_comb begin
    delta         = render_y_i - sprite_y_i;
    height        = height_select_i ? HEIGHT_16 : HEIGHT_8;
    hit_o         = (delta < {4'b0000, height});
    flip_mask     = flip_y_i ? (height_select_i ? 4'hF : 4'h7) : 4'h0;
    line_offset_o = delta[3:0] ^ flip_mask;
  end

endmodule

// File: rtl/vdp_sprite_hit_scan.sv
// Per-raster-line sprite scanner: walks the y_block table one entry per cycle
// and writes the hit list (plus terminator) for the sprite renderer.
module vdp_sprite_hit_scan
  import vdp_sprite_hit_scan_pkg::*;
#(
  parameter int SPRITE_COUNT = 256,
  parameter int MAX_HITS     = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [8:0]  render_y,
  output logic [7:0]  sprite_y_address,
  input  logic [8:0]  sprite_y,
  input  logic        height_select,
  input  logic        flip_y,
  input  logic        width_select,
  output logic [8:0]  hit_list_write_address,
  output logic [13:0] hit_list_write_data,
  output logic        hit_list_write_en,
  output logic [8:0]  hit_count,
  output logic        overflow,
  output logic        scan_done
);

  localparam logic [7:0] LAST_ADDR  = 8'(SPRITE_COUNT - 1);
  localparam logic [8:0] MAX_HITS_C = 9'(MAX_HITS);

  logic [2:0]  state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  ry_q, ry_d;
  logic        vld_p1_q, vld_p1_d;
  logic [7:0]  id_p1_q, id_p1_d;
  logic        we_q, we_d;
  logic [8:0]  wa_q, wa_d;
  logic [13:0] wd_q, wd_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic       hit;
  logic [3:0] line_offset;

  vdp_sprite_y_test u_y_test (
    .render_y_i      (ry_q),
    .sprite_y_i      (sprite_y),
    .height_select_i (height_select),
    .flip_y_i        (flip_y),
    .hit_o           (hit),
    .line_offset_o   (line_offset)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ry_d     = ry_q;
    vld_p1_d = 1'b0;
    id_p1_d  = addr_q;
    we_d     = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    done_d   = done_q;

    if (line_start) begin
      state_d = ST_SCAN;
      addr_d  = 8'd0;
      ry_d    = render_y;
      cnt_d   = 9'd0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          vld_p1_d = 1'b1;
          if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
          else                     addr_d  = addr_q + 8'd1;
        end
        ST_DRAIN: state_d = ST_TERM;
        ST_TERM: begin
          // A full 256-entry list is ended by the renderer's address wrap.
          if (!cnt_q[8]) begin
            we_d = 1'b1;
            wa_d = cnt_q;
            wd_d = HL_TERMINATOR;
          end
          state_d = ST_DONE;
        end
        ST_DONE: done_d = 1'b1;
        default: ;
      endcase

      // Data for the address driven last cycle is evaluated here.
      if (vld_p1_q && (state_q == ST_SCAN || state_q == ST_DRAIN) && hit) begin
        if (cnt_q == MAX_HITS_C) begin
          ovf_d    = 1'b1;
          state_d  = ST_TERM;
          addr_d   = addr_q;
          vld_p1_d = 1'b0;
        end else begin
          we_d  = 1'b1;
          wa_d  = cnt_q;
          wd_d  = hl_entry(id_p1_q, line_offset, width_select);
          cnt_d = cnt_q + 9'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= 8'd0;
      ry_q     <= 9'd0;
      vld_p1_q <= 1'b0;
      id_p1_q  <= 8'd0;
      we_q     <= 1'b0;
      wa_q     <= 9'd0;
      wd_q     <= 14'd0;
      cnt_q    <= 9'd0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ry_q     <= ry_d;
      vld_p1_q <= vld_p1_d;
      id_p1_q  <= id_p1_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign sprite_y_address       = addr_q;
  assign hit_list_write_en      = we_q;
  assign hit_list_write_address = wa_q;
  assign hit_list_write_data    = wd_q;
  assign hit_count              = cnt_q;
  assign overflow               = ovf_q;
  assign scan_done              = done_q;

endmodule

// File: tb/tb_vdp_sprite_hit_scan.sv
// Bench for vdp_sprite_hit_scan: two instances (256-hit and 4-hit capacity)
// share one y_block table and are checked against a line-level list model.
module tb_vdp_sprite_hit_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, line_start;
  logic [8:0]  render_y;

  logic [7:0]  a0, a4, rd0, rd4;
  logic [8:0]  wa0, wa4, hc0, hc4;
  logic [13:0] wd0, wd4;
  logic        we0, we4, ov0, ov4, dn0, dn4;

  logic [8:0] spr_y [256];
  logic       spr_h [256];
  logic       spr_f [256];
  logic       spr_w [256];

  always @(posedge clk) begin
    rd0 <= a0;
    rd4 <= a4;
  end

  vdp_sprite_hit_scan dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .render_y(render_y),
    .sprite_y_address(a0), .sprite_y(spr_y[rd0]), .height_select(spr_h[rd0]),
    .flip_y(spr_f[rd0]), .width_select(spr_w[rd0]),
    .hit_list_write_address(wa0), .hit_list_write_data(wd0), .hit_list_write_en(we0),
    .hit_count(hc0), .overflow(ov0), .scan_done(dn0)
  );

  vdp_sprite_hit_scan #(.MAX_HITS(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .render_y(render_y),
    .sprite_y_address(a4), .sprite_y(spr_y[rd4]), .height_select(spr_h[rd4]),
    .flip_y(spr_f[rd4]), .width_select(spr_w[rd4]),
    .hit_list_write_address(wa4), .hit_list_write_data(wd4), .hit_list_write_en(we4),
    .hit_count(hc4), .overflow(ov4), .scan_done(dn4)
  );

  // Cycle 0 is the cycle in which line_start is high.
  int cyc = 0;
  always @(posedge clk) cyc <= line_start ? 1 : cyc + 1;

  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t got0[$], got4[$], exp_q[$], exp0[$], exp4[$];
  int  dq0[$], dq4[$];
  logic dn0_prev = 1'b1, dn4_prev = 1'b1;

  always @(negedge clk) begin
    if (we0 === 1'b1) got0.push_back('{cyc, int'(wa0), int'(wd0)});
    if (we4 === 1'b1) got4.push_back('{cyc, int'(wa4), int'(wd4)});
    if (dn0 === 1'b1 && dn0_prev !== 1'b1) dq0.push_back(cyc);
    if (dn4 === 1'b1 && dn4_prev !== 1'b1) dq4.push_back(cyc);
    dn0_prev <= dn0;
    dn4_prev <= dn4;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Line-level model: sprite k's entry appears 3 cycles after line_start + k.
  task automatic model(input int ry, input int maxh, output int cnt, output bit ovf,
                       output int done_c);
    int term_c;
    exp_q.delete();
    cnt = 0; ovf = 0; done_c = 260; term_c = 259;
    for (int k = 0; k < 256; k++) begin
      int d, h, off;
      d = (ry - int'(spr_y[k]) + 512) % 512;
      h = spr_h[k] ? 16 : 8;
      if (d < h) begin
        if (cnt == maxh) begin
          ovf = 1; term_c = k + 4; done_c = k + 5;
          break;
        end
        off = spr_f[k] ? (h - 1 - d) : d;
        exp_q.push_back('{k + 3, cnt, (k * 64) + (off * 4) + (int'(spr_w[k]) * 2)});
        cnt++;
      end
    end
    if (cnt < 256) exp_q.push_back('{term_c, cnt, 1});
  endtask

  task automatic clear_table();
    for (int k = 0; k < 256; k++) begin
      spr_y[k] = 9'd300; spr_h[k] = 1'b0; spr_f[k] = 1'b0; spr_w[k] = 1'b0;
    end
  endtask

  task automatic start_line(input int ry);
    @(negedge clk);
    render_y   = 9'(ry);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    got0.delete(); got4.delete(); dq0.delete(); dq4.delete();
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(dn0 === 1'b1 && dn4 === 1'b1) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL scan_timeout: scan_done %b/%b after %0d cycles, required 1/1", dn0, dn4, t);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_table();
    reset_n = 1'b0; line_start = 1'b0; render_y = 9'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (dn0 !== 1'b1) begin n_fail++; $display("FAIL reset_done: got %b expected 1", dn0); end
    n_checks++; if (dn4 !== 1'b1) begin n_fail++; $display("FAIL reset_done4: got %b expected 1", dn4); end
    n_checks++; if (hc0 !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", hc0); end
    n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ov0); end
    n_checks++; if (a0 !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", a0); end
    n_checks++; if (wa0 !== 9'd0 || wd0 !== 14'd0) begin n_fail++; $display("FAIL reset_wr: got addr %0d data %h expected 0 0", wa0, wd0); end
    n_checks++; if (got0.size() + got4.size() != 0) begin n_fail++; $display("FAIL reset_no_write: got %0d writes expected 0", got0.size() + got4.size()); end
  endtask

  task automatic test_directed();
    clear_table();
    spr_y[3] = 9'd95; spr_w[3] = 1'b1;
    spr_y[200] = 9'd90; spr_h[200] = 1'b1; spr_f[200] = 1'b1;
    start_line(100);
    wait_done();
    n_checks++;
    if (got0.size() != 3) begin
      n_fail++; $display("FAIL dir_len: got %0d entries expected 3", got0.size());
    end else begin
      n_checks++; if (got0[0].addr != 0 || got0[0].data != 214 || got0[0].cyc != 6) begin
        n_fail++; $display("FAIL dir_e0: got a%0d d%0d c%0d expected a0 d214 c6", got0[0].addr, got0[0].data, got0[0].cyc); end
      n_checks++; if (got0[1].addr != 1 || got0[1].data != 12820 || got0[1].cyc != 203) begin
        n_fail++; $display("FAIL dir_e1: got a%0d d%0d c%0d expected a1 d12820 c203", got0[1].addr, got0[1].data, got0[1].cyc); end
      n_checks++; if (got0[2].addr != 2 || got0[2].data != 1 || got0[2].cyc != 259) begin
        n_fail++; $display("FAIL dir_term: got a%0d d%0d c%0d expected a2 d1 c259", got0[2].addr, got0[2].data, got0[2].cyc); end
    end
    n_checks++; if (hc0 !== 9'd2) begin n_fail++; $display("FAIL dir_count: got %0d expected 2", hc0); end
    n_checks++; if (dq0.size() != 1 || dq0[0] != 260) begin
      n_fail++; $display("FAIL dir_done_cycle: got %0d expected 260", dq0.size() > 0 ? dq0[0] : -1); end
  endtask

  task automatic test_wrap();
    clear_table();
    spr_y[7] = 9'd508; spr_h[7] = 1'b1;
    start_line(3);
    wait_done();
    n_checks++; if (got0.size() != 2 || got0[0].data != 476 || got0[0].cyc != 10) begin
      n_fail++; $display("FAIL wrap_hit: got %0d entries first d%0d c%0d expected 2 d476 c10",
                         got0.size(), got0.size() > 0 ? got0[0].data : -1, got0.size() > 0 ? got0[0].cyc : -1); end
    start_line(12);
    wait_done();
    n_checks++; if (got0.size() != 1 || got0[0].data != 1 || got0[0].addr != 0) begin
      n_fail++; $display("FAIL wrap_miss: got %0d entries expected terminator only", got0.size()); end
    n_checks++; if (hc0 !== 9'd0) begin n_fail++; $display("FAIL wrap_miss_count: got %0d expected 0", hc0); end
  endtask

  task automatic test_overflow();
    int c0, c4, d0, d4;
    bit o0, o4;
    clear_table();
    for (int k = 0; k < 10; k++) begin spr_y[k] = 9'd40; spr_w[k] = k[0]; end
    model(40, 256, c0, o0, d0); exp0 = exp_q;
    model(40, 4, c4, o4, d4);   exp4 = exp_q;
    start_line(40);
    wait_done();
    n_checks++; if (got4.size() != exp4.size()) begin n_fail++; $display("FAIL ovf_len4: got %0d expected %0d", got4.size(), exp4.size()); end
    for (int i = 0; i < got4.size() && i < exp4.size(); i++) begin
      n_checks++;
      if (got4[i].cyc != exp4[i].cyc || got4[i].addr != exp4[i].addr || got4[i].data != exp4[i].data) begin
        n_fail++; $display("FAIL ovf_entry4[%0d]: got c%0d a%0d d%0d expected c%0d a%0d d%0d", i,
                           got4[i].cyc, got4[i].addr, got4[i].data, exp4[i].cyc, exp4[i].addr, exp4[i].data); end
    end
    n_checks++; if (ov4 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag4: got %b expected 1", ov4); end
    n_checks++; if (hc4 !== 9'd4) begin n_fail++; $display("FAIL ovf_count4: got %0d expected 4", hc4); end
    n_checks++; if (got4.size() != 5 || got4[4].addr != 4 || got4[4].data != 1) begin
      n_fail++; $display("FAIL ovf_term4: got %0d entries expected terminator at address 4", got4.size()); end
    n_checks++; if (dq4.size() != 1 || dq4[0] != d4) begin
      n_fail++; $display("FAIL ovf_done4: got %0d expected %0d", dq4.size() > 0 ? dq4[0] : -1, d4); end
    n_checks++; if (got0.size() != 11 || ov0 !== 1'b0 || hc0 !== 9'd10) begin
      n_fail++; $display("FAIL ovf_full_dut: got %0d entries ovf %b count %0d expected 11 0 10", got0.size(), ov0, hc0); end
  endtask

  task automatic test_all_hit();
    int c0, d0;
    bit o0;
    for (int k = 0; k < 256; k++) begin
      spr_y[k] = 9'd50 - 9'($urandom_range(0, 7));
      spr_h[k] = 1'($urandom_range(0, 1)); spr_f[k] = 1'($urandom_range(0, 1)); spr_w[k] = 1'($urandom_range(0, 1));
    end
    model(50, 256, c0, o0, d0); exp0 = exp_q;
    start_line(50);
    wait_done();
    n_checks++; if (got0.size() != 256 || exp0.size() != 256) begin
      n_fail++; $display("FAIL all_len: got %0d expected 256 (model %0d)", got0.size(), exp0.size()); end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      n_checks++;
      if (got0[i].cyc != exp0[i].cyc || got0[i].addr != exp0[i].addr || got0[i].data != exp0[i].data) begin
        n_fail++; $display("FAIL all_entry[%0d]: got c%0d a%0d d%0d expected c%0d a%0d d%0d", i,
                           got0[i].cyc, got0[i].addr, got0[i].data, exp0[i].cyc, exp0[i].addr, exp0[i].data); end
    end
    n_checks++; if (hc0 !== 9'd256) begin n_fail++; $display("FAIL all_count: got %0d expected 256", hc0); end
    n_checks++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL all_ovf: got %b expected 0", ov0); end
    n_checks++; if (got0.size() > 0 && got0[got0.size()-1].cyc != 258) begin
      n_fail++; $display("FAIL all_last_cycle: got %0d expected 258", got0[got0.size()-1].cyc); end
    n_checks++; if (dq0.size() != 1 || dq0[0] != 260) begin
      n_fail++; $display("FAIL all_done_cycle: got %0d expected 260", dq0.size() > 0 ? dq0[0] : -1); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int ry, c0, c4, d0, d4;
      bit o0, o4;
      ry = int'($urandom_range(0, 511));
      for (int k = 0; k < 256; k++) begin
        if ($urandom_range(0, 3) == 0) spr_y[k] = 9'((ry - int'($urandom_range(0, 20)) + 512) % 512);
        else                           spr_y[k] = 9'($urandom_range(0, 511));
        spr_h[k] = 1'($urandom_range(0, 1)); spr_f[k] = 1'($urandom_range(0, 1)); spr_w[k] = 1'($urandom_range(0, 1));
      end
      model(ry, 256, c0, o0, d0); exp0 = exp_q;
      model(ry, 4, c4, o4, d4);   exp4 = exp_q;
      start_line(ry);
      wait_done();
      n_checks++; if (got0.size() != exp0.size()) begin n_fail++; $display("FAIL rnd_len: got %0d expected %0d", got0.size(), exp0.size()); end
      for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
        n_checks++;
        if (got0[i].cyc != exp0[i].cyc || got0[i].addr != exp0[i].addr || got0[i].data != exp0[i].data) begin
          n_fail++; $display("FAIL rnd_entry[%0d]: got c%0d a%0d d%0d expected c%0d a%0d d%0d", i,
                             got0[i].cyc, got0[i].addr, got0[i].data, exp0[i].cyc, exp0[i].addr, exp0[i].data); end
      end
      n_checks++; if (got4.size() != exp4.size()) begin n_fail++; $display("FAIL rnd_len4: got %0d expected %0d", got4.size(), exp4.size()); end
      for (int i = 0; i < got4.size() && i < exp4.size(); i++) begin
        n_checks++;
        if (got4[i].cyc != exp4[i].cyc || got4[i].addr != exp4[i].addr || got4[i].data != exp4[i].data) begin
          n_fail++; $display("FAIL rnd_entry4[%0d]: got c%0d a%0d d%0d expected c%0d a%0d d%0d", i,
                             got4[i].cyc, got4[i].addr, got4[i].data, exp4[i].cyc, exp4[i].addr, exp4[i].data); end
      end
      n_checks++; if (int'(hc0) != c0 || ov0 !== 1'(o0) || int'(hc4) != c4 || ov4 !== 1'(o4)) begin
        n_fail++; $display("FAIL rnd_status: got %0d/%b %0d/%b expected %0d/%b %0d/%b", hc0, ov0, hc4, ov4, c0, o0, c4, o4); end
      n_checks++; if (dq0.size() != 1 || dq0[0] != d0 || dq4.size() != 1 || dq4[0] != d4) begin
        n_fail++; $display("FAIL rnd_done_cycle: got %0d/%0d expected %0d/%0d",
                           dq0.size() > 0 ? dq0[0] : -1, dq4.size() > 0 ? dq4[0] : -1, d0, d4); end
    end
  endtask

  task automatic test_restart();
    int c0, d0;
    bit o0;
    for (int k = 0; k < 256; k++) begin
      spr_y[k] = 9'($urandom_range(0, 511)); spr_h[k] = 1'($urandom_range(0, 1));
      spr_f[k] = 1'($urandom_range(0, 1));   spr_w[k] = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 256; k += 5) spr_y[k] = 9'd200;
    for (int k = 2; k < 256; k += 7) spr_y[k] = 9'd395;
    model(400, 256, c0, o0, d0); exp0 = exp_q;
    start_line(203);
    while (cyc < 50) @(negedge clk);
    start_line(400);
    wait_done();
    n_checks++; if (got0.size() != exp0.size()) begin n_fail++; $display("FAIL restart_len: got %0d expected %0d", got0.size(), exp0.size()); end
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) begin
      n_checks++;
      if (got0[i].cyc != exp0[i].cyc || got0[i].addr != exp0[i].addr || got0[i].data != exp0[i].data) begin
        n_fail++; $display("FAIL restart_entry[%0d]: got c%0d a%0d d%0d expected c%0d a%0d d%0d", i,
                           got0[i].cyc, got0[i].addr, got0[i].data, exp0[i].cyc, exp0[i].addr, exp0[i].data); end
    end
    start_line(203);
    repeat (30) @(negedge clk);
    n_checks++; if (a0 === 8'd0 || dn0 !== 1'b0) begin
      n_fail++; $display("FAIL midscan_state: got addr %0d done %b expected nonzero 0", a0, dn0); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (dn0 !== 1'b1 || we0 !== 1'b0 || hc0 !== 9'd0 || ov0 !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_status: got done %b we %b count %0d ovf %b expected 1 0 0 0", dn0, we0, hc0, ov0); end
    n_checks++; if (a0 !== 8'd0 || wa0 !== 9'd0 || wd0 !== 14'd0) begin
      n_fail++; $display("FAIL async_reset_bus: got addr %0d waddr %0d wdata %h expected 0 0 0", a0, wa0, wd0); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (dn0 !== 1'b1 || a0 !== 8'd0) begin
      n_fail++; $display("FAIL post_reset_idle: got done %b addr %0d expected 1 0", dn0, a0); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_overflow();
    test_all_hit();
    test_random();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
